// File: rtl/cpu_out_fifo.sv
// Show-ahead output FIFO between the CPU output port and a ready/valid consumer.
// Optional CPU_OUT_FIFO_OVF_CNT_EN adds an 8-bit saturating dropped-write counter.
module cpu_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           cpu_out,
  input  logic                       cpu_out_we,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
`ifdef CPU_OUT_FIFO_OVF_CNT_EN
  output logic [7:0]                 ovf_count,
`endif
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             push, pop, drop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign out_valid = ~empty;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign out_data  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write when draining.
  always_comb begin
    pop  = out_valid & out_ready;
    push = cpu_out_we & (~full | pop);
    drop = cpu_out_we & full & ~pop;
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset; reset gating keeps a held-in-reset edge from writing.
  always_ff @(posedge CLK) begin
    if (push && reset) mem_q[wr_ptr_q] <= cpu_out;
  end

`ifdef CPU_OUT_FIFO_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop) begin
      if (ovf_clr)                 ovf_cnt_d = 8'd1;
      else if (ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
    end else if (ovf_clr) begin
      ovf_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) ovf_cnt_q <= 8'd0;
    else        ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_count = ovf_cnt_q;
`endif

endmodule

// File: doc/cpu_out_fifo.md
CPU_OUT_FIFO -- requirements
Module: cpu_out_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data width of the CPU output bus.
REQ-002 Parameter DEPTH, default 8, number of entries; power of two, 2..256.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 cpu_out  input  WIDTH  data word from the CPU output port.
REQ-006 cpu_out_we  input  1  write strobe from the CPU; one word per cycle high.
REQ-007 out_data  output  WIDTH  head-of-queue word, valid while out_valid=1.
REQ-008 out_valid  output  1  queue non-empty; head word presented.
REQ-009 out_ready  input  1  consumer accepts the head word this cycle.
REQ-010 count  output  $clog2(DEPTH)+1  current number of stored entries.
REQ-011 full  output  1  count==DEPTH.
REQ-012 empty  output  1  count==0.
REQ-013 overflow  output  1  sticky flag: a write was dropped.
REQ-014 ovf_clr  input  1  synchronous clear of overflow.

Function
REQ-015 Circular buffer SHALL use wr_ptr and rd_ptr of $clog2(DEPTH) bits, each wrapping from DEPTH-1 to 0.
REQ-016 Push SHALL occur when cpu_out_we=1 and (full=0 or pop occurs in the same cycle); cpu_out is stored at wr_ptr, wr_ptr increments.
REQ-017 Pop SHALL occur when out_valid=1 and out_ready=1; rd_ptr increments.
REQ-018 out_data SHALL be show-ahead: combinationally the entry at rd_ptr; no read latency.
REQ-019 Write-to-out_valid latency SHALL be one cycle: a word pushed at edge N is visible with out_valid=1 after edge N.
REQ-020 count SHALL be updated as +1 on push only, -1 on pop only, unchanged on push+pop or neither.
REQ-021 Full with cpu_out_we=1 and pop in the same cycle: the write SHALL be accepted; count stays DEPTH; overflow unchanged.
REQ-022 Full with cpu_out_we=1 and no pop: the word SHALL be dropped; storage, pointers and count unchanged; overflow set to 1.
REQ-023 Empty with cpu_out_we=1 and out_ready=1: no pop (out_valid=0); the push is accepted; count becomes 1.
REQ-024 out_ready while empty SHALL have no effect.
REQ-025 ovf_clr=1 SHALL clear overflow next edge; if a drop occurs in the same cycle, set wins (overflow=1).
REQ-026 full, empty and out_valid SHALL be derived from count only (out_valid = ~empty).

Reset
REQ-027 reset=0 SHALL immediately, without waiting for CLK, force wr_ptr=0, rd_ptr=0, count=0, overflow=0; hence empty=1, full=0, out_valid=0.
REQ-028 Storage array contents SHALL NOT be reset; out_data is don't-care while out_valid=0.
REQ-029 Reset asserted mid-operation SHALL discard all queued words; the first push after release becomes the head.
REQ-030 No push or pop SHALL occur on an edge where reset=0.

Configuration
REQ-031 Macro CPU_OUT_FIFO_OVF_CNT_EN defined: an extra output port ovf_count (8 bits) SHALL count dropped writes, saturating at 255, reset to 0, and clear on ovf_clr (increment wins on simultaneous drop and clear, giving 1).
REQ-032 Macro undefined: port ovf_count and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-033 Reset release, then write 0x11,0x22,0x33 on consecutive cycles with out_ready=0 -> count=3, out_data=0x11, out_valid=1, empty=0.
REQ-034 Fill DEPTH=8 with 0x00..0x07, then one more write 0xAA with out_ready=0 -> full=1, count=8, overflow=1, 0xAA never appears at out_data; drain yields 0x00..0x07 in order.
REQ-035 Full FIFO, cpu_out_we=1 with 0xBB and out_ready=1 same cycle -> count stays 8, overflow stays 0, 0xBB emerges as 9th word after 0x01..0x07.
REQ-036 Empty FIFO, cpu_out_we=1 (0x5C) with out_ready=1 -> next cycle out_valid=1, out_data=0x5C, count=1; 20 push/pop cycles verify pointer wrap with no loss.
REQ-037 Queue 4 words, assert reset=0 between clock edges -> out_valid, count, full, overflow go to 0 before the next edge; after release, first write 0x77 appears at head.
REQ-038 With CPU_OUT_FIFO_OVF_CNT_EN: 300 writes into a full, stalled FIFO -> ovf_count=255; ovf_clr with a simultaneous drop -> ovf_count=1, overflow=1.
